bp_nonsynth_tlb_event_monitor: RTL and testbench

Parametrised, multi-channel successor to the per-core VM tracer. Watches N TLB instances (I-TLB, D-TLB, L2 TLB, ...) and keeps per-channel saturating counters for clears, fills, CAM reads and misses. Fill events (vtag, ptag, permissions, cycle stamp) go into a bounded event log that a bench or host drains through a valid/yumi handshake, with overflow accounting. Instantiated next to the core in test harnesses; it has no effect on the design under test.

---
 rtl/bp_nonsynth_tlb_event_monitor.sv | 176 +++++++++++++++++
 tb/tb_bp_nonsynth_tlb_event_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_nonsynth_tlb_event_monitor.sv
// Non-intrusive TLB event monitor: per-channel saturating event counters plus
// a bounded log of fill events drained through a valid/yumi handshake.
module bp_nonsynth_tlb_event_monitor #(
    parameter int num_tlb_p     = 2,
    parameter int vtag_width_p  = 27,
    parameter int ptag_width_p  = 28,
    parameter int count_width_p = 32,
    parameter int log_els_p     = 8,
    localparam int chan_w_lp    = (num_tlb_p > 1) ? $clog2(num_tlb_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              freeze_i,
    input  logic [num_tlb_p-1:0]              clear_v_i,
    input  logic [num_tlb_p-1:0]              fill_v_i,
    input  logic [num_tlb_p*vtag_width_p-1:0] fill_vtag_i,
    input  logic [num_tlb_p*ptag_width_p-1:0] fill_ptag_i,
    input  logic [num_tlb_p*3-1:0]            fill_perm_i,
    input  logic [num_tlb_p-1:0]              cam_r_v_i,
    input  logic [num_tlb_p-1:0]              miss_v_i,
    input  logic                              counters_clear_i,
    input  logic [chan_w_lp-1:0]              count_chan_i,
    input  logic [1:0]                        count_type_i,
    output logic [count_width_p-1:0]          count_o,
    output logic [count_width_p-1:0]          drop_count_o,
    output logic                              log_v_o,
    input  logic                              log_yumi_i,
    output logic [chan_w_lp-1:0]              log_chan_o,
    output logic [vtag_width_p-1:0]           log_vtag_o,
    output logic [ptag_width_p-1:0]           log_ptag_o,
    output logic [2:0]                        log_perm_o,
    output logic [count_width_p-1:0]          log_stamp_o
);

    // Log handshake: log_v_o marks a valid head; log_yumi_i consumes it in the
    // same cycle and is ignored while the log is empty.
    localparam int ptr_w_lp = $clog2(log_els_p);
    localparam int pc_w_lp  = $clog2(num_tlb_p + 1);
    localparam int ent_w_lp = chan_w_lp + vtag_width_p + ptag_width_p + 3 + count_width_p;

    logic [count_width_p-1:0] cnt_q [num_tlb_p][4];
    logic [count_width_p-1:0] cnt_d [num_tlb_p][4];
    logic [count_width_p-1:0] drop_q, drop_d;
    logic [count_width_p-1:0] stamp_q, stamp_d;
    logic [ent_w_lp-1:0]      mem_q [log_els_p];
    logic [ent_w_lp-1:0]      mem_d [log_els_p];
    logic [ptr_w_lp-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ptr_w_lp:0]        log_cnt_q, log_cnt_d;

    logic [3:0]               strobe;
    logic                     win_found;
    logic [chan_w_lp-1:0]     win_idx;
    int                       win_int;
    logic [pc_w_lp-1:0]       nfill;
    logic [pc_w_lp-1:0]       ndrop;
    logic [count_width_p:0]   drop_sum;
    logic                     full, enq, deq;
    logic [ent_w_lp-1:0]      new_ent;

    always_comb begin
        strobe = '0;
        cnt_d  = cnt_q;
        for (int i = 0; i < num_tlb_p; i++) begin
            strobe = {miss_v_i[i], cam_r_v_i[i], fill_v_i[i], clear_v_i[i]};
            for (int t = 0; t < 4; t++) begin
                if (counters_clear_i) begin
                    cnt_d[i][t] = '0;
                end else if (!freeze_i && strobe[t] && (cnt_q[i][t] != '1)) begin
                    cnt_d[i][t] = cnt_q[i][t] + count_width_p'(1);
                end
            end
        end
    end

    // Lowest-index fill wins the single log write port; the rest are drops.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_int   = 0;
        nfill     = '0;
        for (int i = 0; i < num_tlb_p; i++) begin
            if (fill_v_i[i]) begin
                nfill = nfill + pc_w_lp'(1);
                if (!win_found) begin
                    win_found = 1'b1;
                    win_idx   = chan_w_lp'(i);
                    win_int   = i;
                end
            end
        end
    end

    always_comb begin
        full    = (log_cnt_q == (ptr_w_lp+1)'(log_els_p));
        deq     = log_yumi_i && (log_cnt_q != '0);
        enq     = win_found && !freeze_i && (!full || log_yumi_i);
        new_ent = {win_idx,
                   fill_vtag_i[win_int*vtag_width_p +: vtag_width_p],
                   fill_ptag_i[win_int*ptag_width_p +: ptag_width_p],
                   fill_perm_i[win_int*3 +: 3],
                   stamp_q};

        ndrop = '0;
        if (win_found && !freeze_i) begin
            ndrop = enq ? (nfill - pc_w_lp'(1)) : nfill;
        end
        drop_sum = {1'b0, drop_q} + (count_width_p+1)'(ndrop);
        if (counters_clear_i) begin
            drop_d = '0;
        end else if (drop_sum[count_width_p]) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[count_width_p-1:0];
        end

        stamp_d = freeze_i ? stamp_q : stamp_q + count_width_p'(1);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (enq) begin
            mem_d[wr_ptr_q] = new_ent;
            wr_ptr_d        = wr_ptr_q + ptr_w_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1);
        end

        log_cnt_d = log_cnt_q;
        if (enq && !deq) begin
            log_cnt_d = log_cnt_q + (ptr_w_lp+1)'(1);
        end else if (deq && !enq) begin
            log_cnt_d = log_cnt_q - (ptr_w_lp+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_tlb_p; i++) begin
                for (int t = 0; t < 4; t++) begin
                    cnt_q[i][t] <= '0;
                end
            end
            drop_q    <= '0;
            stamp_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            log_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            stamp_q   <= stamp_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            log_cnt_q <= log_cnt_d;
        end
    end

    // Log storage needs no reset: the pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_comb begin
        count_o = '0;
        if (int'(count_chan_i) < num_tlb_p) begin
            count_o = cnt_q[count_chan_i][count_type_i];
        end
    end

    assign drop_count_o = drop_q;
    assign log_v_o      = (log_cnt_q != '0);
    assign {log_chan_o, log_vtag_o, log_ptag_o, log_perm_o, log_stamp_o} = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bp_nonsynth_tlb_event_monitor.sv
// Directed bench for the TLB event monitor: a queue/array reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_bp_nonsynth_tlb_event_monitor;

  localparam int N   = 3;
  localparam int VW  = 12;
  localparam int PW  = 12;
  localparam int CW  = 4;
  localparam int LE  = 8;
  localparam int CHW = 2;
  localparam int EW  = CHW + VW + PW + 3 + CW;
  localparam int SAT = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              freeze = 1'b0;
  logic [N-1:0]      clear_v = '0;
  logic [N-1:0]      fill_v = '0;
  logic [N*VW-1:0]   fill_vtag = '0;
  logic [N*PW-1:0]   fill_ptag = '0;
  logic [N*3-1:0]    fill_perm = '0;
  logic [N-1:0]      cam_r_v = '0;
  logic [N-1:0]      miss_v = '0;
  logic              counters_clear = 1'b0;
  logic [CHW-1:0]    count_chan = '0;
  logic [1:0]        count_type = '0;
  logic [CW-1:0]     count_o;
  logic [CW-1:0]     drop_count_o;
  logic              log_v_o;
  logic              log_yumi = 1'b0;
  logic [CHW-1:0]    log_chan_o;
  logic [VW-1:0]     log_vtag_o;
  logic [PW-1:0]     log_ptag_o;
  logic [2:0]        log_perm_o;
  logic [CW-1:0]     log_stamp_o;

  bp_nonsynth_tlb_event_monitor #(
    .num_tlb_p(N), .vtag_width_p(VW), .ptag_width_p(PW),
    .count_width_p(CW), .log_els_p(LE)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .freeze_i(freeze),
    .clear_v_i(clear_v), .fill_v_i(fill_v), .fill_vtag_i(fill_vtag),
    .fill_ptag_i(fill_ptag), .fill_perm_i(fill_perm), .cam_r_v_i(cam_r_v),
    .miss_v_i(miss_v), .counters_clear_i(counters_clear),
    .count_chan_i(count_chan), .count_type_i(count_type), .count_o(count_o),
    .drop_count_o(drop_count_o), .log_v_o(log_v_o), .log_yumi_i(log_yumi),
    .log_chan_o(log_chan_o), .log_vtag_o(log_vtag_o), .log_ptag_o(log_ptag_o),
    .log_perm_o(log_perm_o), .log_stamp_o(log_stamp_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // reference model
  int               cnt_m [N][4];
  int               drop_m;
  int               stamp_m;
  logic [EW-1:0]    exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int nf;
    int first;
    bit full;
    logic [EW-1:0] e;
    if (!reset_n) begin
      for (int i = 0; i < N; i++)
        for (int t = 0; t < 4; t++) cnt_m[i][t] = 0;
      drop_m = 0;
      stamp_m = 0;
      exp_q.delete();
    end else begin
      full = (exp_q.size() >= LE);
      if (log_yumi && exp_q.size() > 0) void'(exp_q.pop_front());
      if (!freeze) begin
        for (int i = 0; i < N; i++) begin
          if (clear_v[i]) cnt_m[i][0] = (cnt_m[i][0] + 1 > SAT) ? SAT : cnt_m[i][0] + 1;
          if (fill_v[i])  cnt_m[i][1] = (cnt_m[i][1] + 1 > SAT) ? SAT : cnt_m[i][1] + 1;
          if (cam_r_v[i]) cnt_m[i][2] = (cnt_m[i][2] + 1 > SAT) ? SAT : cnt_m[i][2] + 1;
          if (miss_v[i])  cnt_m[i][3] = (cnt_m[i][3] + 1 > SAT) ? SAT : cnt_m[i][3] + 1;
        end
        nf = 0;
        first = -1;
        for (int i = 0; i < N; i++) begin
          if (fill_v[i]) begin
            nf++;
            if (first < 0) first = i;
          end
        end
        if (nf > 0) begin
          if (!full || log_yumi) begin
            e = {CHW'(first), fill_vtag[first*VW +: VW], fill_ptag[first*PW +: PW],
                 fill_perm[first*3 +: 3], CW'(stamp_m)};
            exp_q.push_back(e);
            drop_m += nf - 1;
          end else begin
            drop_m += nf;
          end
          if (drop_m > SAT) drop_m = SAT;
        end
      end
      if (counters_clear) begin
        for (int i = 0; i < N; i++)
          for (int t = 0; t < 4; t++) cnt_m[i][t] = 0;
        drop_m = 0;
      end
      if (!freeze) stamp_m = (stamp_m + 1) % (SAT + 1);
    end
  end

  // scoreboard compare, every cycle on the inactive edge
  always @(negedge clk) begin
    int exp_cnt;
    if (cmp_en) begin
      exp_cnt = (int'(count_chan) < N) ? cnt_m[count_chan][count_type] : 0;
      chk("count_o", 64'(count_o), 64'(exp_cnt));
      chk("drop_count_o", 64'(drop_count_o), 64'(drop_m));
      chk("log_v_o", 64'(log_v_o), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("log_head", 64'({log_chan_o, log_vtag_o, log_ptag_o, log_perm_o, log_stamp_o}),
            64'(exp_q[0]));
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_fill(input int ch, input logic [VW-1:0] vt, input logic [PW-1:0] pt,
                          input logic [2:0] pm);
    fill_vtag[ch*VW +: VW] = vt;
    fill_ptag[ch*PW +: PW] = pt;
    fill_perm[ch*3 +: 3]   = pm;
  endtask

  initial begin
    reset_n = 1'b0;
    cyc(3);
    cmp_en = 1'b1;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_drop", 64'(drop_count_o), 64'd0);
    chk("rst_log_v", 64'(log_v_o), 64'd0);
    reset_n = 1'b1;
    cyc(10);

    // first fill after 10 idle cycles carries stamp 10
    set_fill(0, 12'h123, 12'h456, 3'b011);
    fill_v = 3'b001;
    count_chan = 2'd0;
    count_type = 2'd1;
    cyc(1);
    fill_v = '0;
    chk("fill0_v", 64'(log_v_o), 64'd1);
    chk("fill0_chan", 64'(log_chan_o), 64'd0);
    chk("fill0_vtag", 64'(log_vtag_o), 64'h123);
    chk("fill0_ptag", 64'(log_ptag_o), 64'h456);
    chk("fill0_perm", 64'(log_perm_o), 64'b011);
    chk("fill0_stamp", 64'(log_stamp_o), 64'd10);
    chk("fill0_count", 64'(count_o), 64'd1);
    log_yumi = 1'b1;
    cyc(1);
    log_yumi = 1'b0;
    chk("drain0_v", 64'(log_v_o), 64'd0);

    // simultaneous fills: lowest channel logged, others dropped
    set_fill(0, 12'h0a1, 12'h0b1, 3'b001);
    set_fill(1, 12'h0a2, 12'h0b2, 3'b010);
    set_fill(2, 12'h0a3, 12'h0b3, 3'b100);
    fill_v = 3'b011;
    cyc(1);
    fill_v = '0;
    chk("dual_drop", 64'(drop_count_o), 64'd1);
    chk("dual_chan", 64'(log_chan_o), 64'd0);
    chk("dual_vtag", 64'(log_vtag_o), 64'h0a1);
    count_chan = 2'd1;
    #1;
    chk("dual_ch1_fill", 64'(count_o), 64'd1);
    fill_v = 3'b111;
    cyc(1);
    fill_v = '0;
    chk("triple_drop", 64'(drop_count_o), 64'd3);
    log_yumi = 1'b1;
    cyc(2);
    log_yumi = 1'b0;
    chk("drain1_v", 64'(log_v_o), 64'd0);
    fill_v = 3'b100;
    cyc(1);
    fill_v = '0;
    chk("ch2_chan", 64'(log_chan_o), 64'd2);
    chk("ch2_vtag", 64'(log_vtag_o), 64'h0a3);
    log_yumi = 1'b1;
    cyc(1);
    log_yumi = 1'b0;

    // fill past capacity, then enqueue while full with a same-cycle dequeue
    for (int i = 0; i < 9; i++) begin
      set_fill(1, 12'(12'h100 + i), 12'(12'h300 + i), 3'(i));
      fill_v = 3'b010;
      cyc(1);
    end
    fill_v = '0;
    chk("full_drop", 64'(drop_count_o), 64'd4);
    chk("full_head", 64'(log_vtag_o), 64'h100);
    set_fill(1, 12'h200, 12'h3ff, 3'b111);
    fill_v = 3'b010;
    log_yumi = 1'b1;
    cyc(1);
    fill_v = '0;
    chk("fullswap_drop", 64'(drop_count_o), 64'd4);
    chk("fullswap_head", 64'(log_vtag_o), 64'h101);
    cyc(7);
    chk("fullswap_tail", 64'(log_vtag_o), 64'h200);
    cyc(1);
    log_yumi = 1'b0;
    chk("fullswap_empty", 64'(log_v_o), 64'd0);

    // saturation and clear-wins
    count_chan = 2'd1;
    count_type = 2'd2;
    cam_r_v = 3'b010;
    cyc(20);
    chk("sat_read", 64'(count_o), 64'd15);
    counters_clear = 1'b1;
    miss_v = 3'b111;
    cyc(1);
    counters_clear = 1'b0;
    cam_r_v = '0;
    miss_v = '0;
    chk("clr_read", 64'(count_o), 64'd0);
    chk("clr_drop", 64'(drop_count_o), 64'd0);

    // out-of-range channel select reads zero
    miss_v = 3'b111;
    clear_v = 3'b101;
    cyc(3);
    miss_v = '0;
    clear_v = '0;
    count_chan = 2'd3;
    count_type = 2'd3;
    #1;
    chk("chan_oob", 64'(count_o), 64'd0);
    count_chan = 2'd2;
    #1;
    chk("ch2_miss", 64'(count_o), 64'd3);
    count_chan = 2'd0;
    count_type = 2'd0;
    #1;
    chk("ch0_clear", 64'(count_o), 64'd3);

    // freeze: no counting/logging, but yumi still drains
    set_fill(0, 12'h555, 12'h666, 3'b101);
    fill_v = 3'b001;
    cyc(1);
    set_fill(2, 12'h777, 12'h888, 3'b110);
    fill_v = 3'b100;
    cyc(1);
    freeze = 1'b1;
    fill_v = 3'b111;
    cam_r_v = 3'b111;
    miss_v = 3'b111;
    clear_v = 3'b111;
    log_yumi = 1'b1;
    cyc(5);
    freeze = 1'b0;
    fill_v = '0;
    cam_r_v = '0;
    miss_v = '0;
    clear_v = '0;
    log_yumi = 1'b0;
    chk("frz_log_v", 64'(log_v_o), 64'd0);
    chk("frz_ch0_clear", 64'(count_o), 64'd3);
    chk("frz_drop", 64'(drop_count_o), 64'd0);
    set_fill(1, 12'h0c1, 12'h0d1, 3'b001);
    fill_v = 3'b010;
    cyc(1);
    fill_v = '0;
    log_yumi = 1'b1;
    cyc(1);
    log_yumi = 1'b0;

    // reset mid-drain discards the log and restarts the stamp
    set_fill(0, 12'h0e0, 12'h0f0, 3'b010);
    fill_v = 3'b001;
    cyc(3);
    fill_v = '0;
    log_yumi = 1'b1;
    cyc(1);
    log_yumi = 1'b0;
    reset_n = 1'b0;
    cyc(1);
    chk("rst2_log_v", 64'(log_v_o), 64'd0);
    chk("rst2_count", 64'(count_o), 64'd0);
    reset_n = 1'b1;
    cyc(2);
    fill_v = 3'b001;
    cyc(1);
    fill_v = '0;
    chk("rst2_stamp", 64'(log_stamp_o), 64'd2);
    log_yumi = 1'b1;
    cyc(1);
    log_yumi = 1'b0;
    cyc(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
